// File: rtl/aes_wb_pkg.sv
// Constants shared by the AES Wishbone master and slave: base address,
// control-word fields, transfer counts and the master state encoding.
package aes_wb_pkg;

  localparam logic [31:0] SLAVE_BASE_ADR   = 32'h3000_0000;

  localparam logic [3:0]  ENABLE_NIB       = 4'hE;
  localparam logic [7:0]  ENC_CODE         = 8'hEC;
  localparam logic [7:0]  DEC_CODE         = 8'hDE;
  localparam logic [3:0]  ORDER_KEY_FIRST  = 4'h0;
  localparam logic [3:0]  ORDER_TEXT_FIRST = 4'h1;

  localparam int          NUM_WR           = 9;
  localparam int          NUM_RD           = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_GAP,
    S_RD_REQ,
    S_RD_GAP,
    S_DONE,
    S_ERR
  } mst_state_t;

  // Final write of the sequence: starts the core in the requested direction.
  function automatic logic [31:0] ctrl_word(input logic order, input logic mode);
    return {(order ? ORDER_TEXT_FIRST : ORDER_KEY_FIRST), ENABLE_NIB,
            (mode ? ENC_CODE : DEC_CODE), 16'h0000};
  endfunction

endpackage

// File: rtl/aes_wb_if.sv
// Wishbone classic initiator bundle between aes_wb_master and the AES slave.
interface aes_wb_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/aes_wb_master.sv
// Drives 9 writes (key, text, control) then 4 reads to the AES slave per start.
// Latency 27 cycles start-to-done with zero-wait acks; waits on ack per transfer up to TIMEOUT_CYCLES.
module aes_wb_master
  import aes_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADR       = SLAVE_BASE_ADR,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          GAP_CYCLES     = 1
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic         order_i,
  input  logic [127:0] key_i,
  input  logic [127:0] text_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [127:0] result_o,
  aes_wb_if.master     wbm
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  mst_state_t     state_q, state_d;
  logic [127:0]   key_q, text_q, rd_buf_q;
  logic           mode_q, order_q;
  logic [3:0]     word_idx_q;
  logic [2:0]     rd_idx_q;
  logic [TW-1:0]  to_cnt_q;
  logic [GW-1:0]  gap_cnt_q;

  logic [127:0]   wr_quad;
  logic [31:0]    wr_word;
  logic           ack, to_hit, gap_end;

  assign ack     = wbm.wbm_ack_i;
  assign to_hit  = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign gap_end = (gap_cnt_q == GW'(GAP_CYCLES - 1));
  assign busy_o  = (state_q != S_IDLE);

  // Words 0-3 come from the first quad, 4-7 from the other, word 8 is control.
  always_comb begin
    wr_quad = (word_idx_q[2] ^ order_q) ? text_q : key_q;
    case (word_idx_q[1:0])
      2'd0:    wr_word = wr_quad[127:96];
      2'd1:    wr_word = wr_quad[95:64];
      2'd2:    wr_word = wr_quad[63:32];
      default: wr_word = wr_quad[31:0];
    endcase
    if (word_idx_q[3]) wr_word = ctrl_word(order_q, mode_q);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    done_o         = 1'b0;
    wbm.wbm_cyc_o  = 1'b0;
    wbm.wbm_stb_o  = 1'b0;
    wbm.wbm_we_o   = 1'b0;
    wbm.wbm_sel_o  = 4'h0;
    wbm.wbm_adr_o  = 32'h0;
    wbm.wbm_dat_o  = 32'h0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_WR_REQ;
      S_WR_REQ: begin
        wbm.wbm_cyc_o = 1'b1;
        wbm.wbm_stb_o = 1'b1;
        wbm.wbm_we_o  = 1'b1;
        wbm.wbm_sel_o = 4'hF;
        wbm.wbm_adr_o = BASE_ADR;
        wbm.wbm_dat_o = wr_word;
        if (ack)         state_d = S_WR_GAP;
        else if (to_hit) state_d = S_ERR;
      end
      S_WR_GAP: begin
        wbm.wbm_cyc_o = 1'b1;
        if (gap_end) state_d = (word_idx_q < 4'(NUM_WR)) ? S_WR_REQ : S_RD_REQ;
      end
      S_RD_REQ: begin
        wbm.wbm_cyc_o = 1'b1;
        wbm.wbm_stb_o = 1'b1;
        wbm.wbm_sel_o = 4'hF;
        wbm.wbm_adr_o = BASE_ADR;
        if (ack)         state_d = S_RD_GAP;
        else if (to_hit) state_d = S_ERR;
      end
      S_RD_GAP: begin
        wbm.wbm_cyc_o = 1'b1;
        if (gap_end) state_d = (rd_idx_q < 3'(NUM_RD)) ? S_RD_REQ : S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      key_q      <= '0;
      text_q     <= '0;
      mode_q     <= 1'b0;
      order_q    <= 1'b0;
      word_idx_q <= '0;
      rd_idx_q   <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      rd_buf_q   <= '0;
      result_o   <= '0;
      err_o      <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        key_q      <= key_i;
        text_q     <= text_i;
        mode_q     <= mode_i;
        order_q    <= order_i;
        err_o      <= 1'b0;
        word_idx_q <= '0;
        rd_idx_q   <= '0;
      end

      // Timeout counts strobe-high cycles of the current request only.
      if (wbm.wbm_stb_o && !ack) to_cnt_q <= to_cnt_q + TW'(1);
      else                       to_cnt_q <= '0;

      if (state_q == S_WR_GAP || state_q == S_RD_GAP) gap_cnt_q <= gap_cnt_q + GW'(1);
      else                                             gap_cnt_q <= '0;

      if (state_q == S_WR_REQ && ack) word_idx_q <= word_idx_q + 4'd1;

      if (state_q == S_RD_REQ && ack) begin
        rd_idx_q <= rd_idx_q + 3'd1;
        case (rd_idx_q[1:0])
          2'd0:    rd_buf_q[127:96] <= wbm.wbm_dat_i;
          2'd1:    rd_buf_q[95:64]  <= wbm.wbm_dat_i;
          2'd2:    rd_buf_q[63:32]  <= wbm.wbm_dat_i;
          default: rd_buf_q[31:0]   <= wbm.wbm_dat_i;
        endcase
      end

      if (state_q == S_RD_GAP && state_d == S_DONE) result_o <= rd_buf_q;
      if (state_q != S_ERR && state_d == S_ERR)     err_o    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_wb_master.sv
// Bench for aes_wb_master against a behavioural AES slave that answers with
// known-answer vectors; write words are scoreboarded against a reference model.
module tb_aes_wb_master;
  import aes_wb_pkg::*;

  localparam int           TO       = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         wb_clk_i  = 1'b0;
  logic         wb_rst_ni = 1'b0;
  logic         start_i   = 1'b0;
  logic         mode_i    = 1'b0;
  logic         order_i   = 1'b0;
  logic [127:0] key_i     = '0;
  logic [127:0] text_i    = '0;
  logic         busy_o, done_o, err_o;
  logic [127:0] result_o;

  aes_wb_if wbm();

  aes_wb_master #(
    .BASE_ADR       (32'h3000_0000),
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (1)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .start_i   (start_i),
    .mode_i    (mode_i),
    .order_i   (order_i),
    .key_i     (key_i),
    .text_i    (text_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .result_o  (result_o),
    .wbm       (wbm)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int tests = 0;
  int fails = 0;

  // Slave model: combinational ack, optional stall on one write, optional forced ack.
  logic         ack_force = 1'b0;
  int           no_ack_wr = -1;
  int           slow_wr   = -1;
  int           slow_lat  = 0;
  logic [127:0] rsp_blk   = '0;
  int           wr_cnt    = 0;
  int           rd_cnt    = 0;
  int           wait_cnt  = 0;
  logic         lat_ok;
  logic [31:0]  rsp_word;

  always_comb lat_ok = (wait_cnt >= ((wr_cnt == slow_wr) ? slow_lat : 0));
  always_comb begin
    rsp_word = 32'h0;
    if (rd_cnt >= 0 && rd_cnt < 4) rsp_word = 32'(rsp_blk >> (32 * (3 - rd_cnt)));
  end

  assign wbm.wbm_dat_i = rsp_word;
  assign wbm.wbm_ack_i = ack_force ||
                         (wbm.wbm_cyc_o && wbm.wbm_stb_o &&
                          (!wbm.wbm_we_o || ((wr_cnt != no_ack_wr) && lat_ok)));

  always @(posedge wb_clk_i) begin
    if (!wbm.wbm_cyc_o) begin
      wr_cnt <= 0;
      rd_cnt <= 0;
    end else if (wbm.wbm_stb_o && wbm.wbm_ack_i) begin
      if (wbm.wbm_we_o) wr_cnt <= wr_cnt + 1;
      else              rd_cnt <= rd_cnt + 1;
    end
    if (wbm.wbm_stb_o && !wbm.wbm_ack_i) wait_cnt <= wait_cnt + 1;
    else                                 wait_cnt <= 0;
  end

  // Bus monitor: records accepted writes and tallies protocol anomalies.
  logic [31:0] obs_wr[$];
  int n_rd = 0, bus_bad = 0, gap_bad = 0, cyc_bad = 0, gap_run = 0;

  always @(negedge wb_clk_i) begin
    if (wbm.wbm_cyc_o && wbm.wbm_stb_o && wbm.wbm_ack_i) begin
      if (wbm.wbm_we_o) obs_wr.push_back(wbm.wbm_dat_o);
      else              n_rd <= n_rd + 1;
      if (wbm.wbm_adr_o !== 32'h3000_0000 || wbm.wbm_sel_o !== 4'hF ||
          (!wbm.wbm_we_o && wbm.wbm_dat_o !== 32'h0))
        bus_bad <= bus_bad + 1;
    end
    if (wbm.wbm_cyc_o && !wbm.wbm_stb_o) gap_run <= gap_run + 1;
    else begin
      if (wbm.wbm_stb_o && gap_run != 0 && gap_run != 1) gap_bad <= gap_bad + 1;
      gap_run <= 0;
    end
    if (busy_o && !wbm.wbm_cyc_o && !done_o) cyc_bad <= cyc_bad + 1;
  end

  logic [31:0] exp_wr[$];
  int wr_base = 0, rd_base = 0, gap0 = 0, bus0 = 0, cyc0 = 0;

  task automatic push_expected(input logic [127:0] k, input logic [127:0] t,
                               input logic m, input logic o);
    logic [127:0] q0, q1;
    q0 = o ? t : k;
    q1 = o ? k : t;
    for (int i = 0; i < 4; i++) exp_wr.push_back(32'(q0 >> (96 - 32 * i)));
    for (int i = 0; i < 4; i++) exp_wr.push_back(32'(q1 >> (96 - 32 * i)));
    exp_wr.push_back({3'b000, o, 4'hE, (m ? 8'hEC : 8'hDE), 16'h0000});
  endtask

  task automatic start_seq(input logic [127:0] k, input logic [127:0] t,
                           input logic m, input logic o);
    @(negedge wb_clk_i);
    key_i   = k;
    text_i  = t;
    mode_i  = m;
    order_i = o;
    start_i = 1'b1;
    exp_wr.delete();
    push_expected(k, t, m, o);
    wr_base = obs_wr.size();
    rd_base = n_rd;
    gap0    = gap_bad;
    bus0    = bus_bad;
    cyc0    = cyc_bad;
    @(posedge wb_clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge wb_clk_i);
      if (done_o) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    tests++; if ({wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o} !== 3'b000) begin
      fails++; $display("FAIL rst_cyc_stb_we got %b want 000", {wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o}); end
    tests++; if (wbm.wbm_sel_o !== 4'h0 || wbm.wbm_adr_o !== 32'h0 || wbm.wbm_dat_o !== 32'h0) begin
      fails++; $display("FAIL rst_sel_adr_dat got %h/%h/%h want 0", wbm.wbm_sel_o, wbm.wbm_adr_o, wbm.wbm_dat_o); end
    tests++; if ({busy_o, done_o, err_o} !== 3'b000) begin
      fails++; $display("FAIL rst_status got %b want 000", {busy_o, done_o, err_o}); end
    tests++; if (result_o !== 128'h0) begin
      fails++; $display("FAIL rst_result got %h want 0", result_o); end
    wb_rst_ni = 1'b1;
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic test_encrypt();
    int lat; bit seen; logic [31:0] e, w8;
    rsp_blk = FIPS_CT;
    start_seq(FIPS_KEY, FIPS_PT, 1'b1, 1'b0);
    wait_done(lat, seen);
    tests++; if (!seen || lat != 27) begin
      fails++; $display("FAIL enc_latency got %0d (seen=%0b) want 27", lat, seen); end
    tests++; if (result_o !== FIPS_CT) begin
      fails++; $display("FAIL enc_result got %h want %h", result_o, FIPS_CT); end
    tests++; if (err_o !== 1'b0 || {wbm.wbm_cyc_o, wbm.wbm_stb_o} !== 2'b00) begin
      fails++; $display("FAIL enc_done_state got err=%b cyc/stb=%b want 0/00", err_o, {wbm.wbm_cyc_o, wbm.wbm_stb_o}); end
    tests++; if (obs_wr.size() - wr_base != 9 || n_rd - rd_base != 4) begin
      fails++; $display("FAIL enc_xfers got %0d wr %0d rd want 9 wr 4 rd", obs_wr.size() - wr_base, n_rd - rd_base); end
    w8 = (obs_wr.size() > wr_base + 8) ? obs_wr[wr_base + 8] : 32'hxxxx_xxxx;
    tests++; if (w8 !== 32'h0EEC0000) begin
      fails++; $display("FAIL enc_word8 got %h want 0eec0000", w8); end
    while (wr_base < obs_wr.size()) begin
      e = (exp_wr.size() != 0) ? exp_wr.pop_front() : 32'hxxxx_xxxx;
      tests++; if (obs_wr[wr_base] !== e) begin
        fails++; $display("FAIL enc_wr got %h want %h", obs_wr[wr_base], e); end
      wr_base++;
    end
    tests++; if (gap_bad != gap0 || bus_bad != bus0 || cyc_bad != cyc0) begin
      fails++; $display("FAIL enc_protocol got gap/bus/cyc errs %0d/%0d/%0d want 0", gap_bad - gap0, bus_bad - bus0, cyc_bad - cyc0); end
    @(negedge wb_clk_i);
    tests++; if ({busy_o, done_o} !== 2'b00) begin
      fails++; $display("FAIL enc_after got busy/done %b want 00", {busy_o, done_o}); end
  endtask

  task automatic test_decrypt();
    int lat; bit seen; logic [31:0] e, w0, w8;
    rsp_blk = FIPS_PT;
    start_seq(FIPS_KEY, FIPS_CT, 1'b0, 1'b1);
    wait_done(lat, seen);
    tests++; if (!seen || lat != 27) begin
      fails++; $display("FAIL dec_latency got %0d (seen=%0b) want 27", lat, seen); end
    tests++; if (result_o !== FIPS_PT || err_o !== 1'b0) begin
      fails++; $display("FAIL dec_result got %h err=%b want %h err=0", result_o, err_o, FIPS_PT); end
    w0 = (obs_wr.size() > wr_base)     ? obs_wr[wr_base]     : 32'hxxxx_xxxx;
    w8 = (obs_wr.size() > wr_base + 8) ? obs_wr[wr_base + 8] : 32'hxxxx_xxxx;
    tests++; if (w0 !== 32'h69c4e0d8 || w8 !== 32'h1EDE0000) begin
      fails++; $display("FAIL dec_words got w0=%h w8=%h want 69c4e0d8/1ede0000", w0, w8); end
    tests++; if (obs_wr.size() - wr_base != 9) begin
      fails++; $display("FAIL dec_wr_count got %0d want 9", obs_wr.size() - wr_base); end
    while (wr_base < obs_wr.size()) begin
      e = (exp_wr.size() != 0) ? exp_wr.pop_front() : 32'hxxxx_xxxx;
      tests++; if (obs_wr[wr_base] !== e) begin
        fails++; $display("FAIL dec_wr got %h want %h", obs_wr[wr_base], e); end
      wr_base++;
    end
  endtask

  task automatic test_slow_ack();
    int lat; bit seen;
    rsp_blk  = FIPS_CT;
    slow_wr  = 8;
    slow_lat = 10;
    start_seq(FIPS_KEY, FIPS_PT, 1'b1, 1'b0);
    wait_done(lat, seen);
    tests++; if (!seen || lat != 37 || err_o !== 1'b0) begin
      fails++; $display("FAIL slow_latency got %0d err=%b want 37 err=0", lat, err_o); end
    tests++; if (result_o !== FIPS_CT) begin
      fails++; $display("FAIL slow_result got %h want %h", result_o, FIPS_CT); end
    slow_wr = -1;
  endtask

  task automatic test_timeout();
    int lat; bit seen; logic [31:0] e;
    rsp_blk   = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
    no_ack_wr = 3;
    start_seq(~FIPS_KEY, FIPS_PT, 1'b1, 1'b0);
    wait_done(lat, seen);
    tests++; if (!seen || lat != 23) begin
      fails++; $display("FAIL to_latency got %0d (seen=%0b) want 23", lat, seen); end
    tests++; if (err_o !== 1'b1 || {wbm.wbm_cyc_o, wbm.wbm_stb_o} !== 2'b00) begin
      fails++; $display("FAIL to_err got err=%b cyc/stb=%b want 1/00", err_o, {wbm.wbm_cyc_o, wbm.wbm_stb_o}); end
    tests++; if (result_o !== FIPS_CT) begin
      fails++; $display("FAIL to_result_kept got %h want %h", result_o, FIPS_CT); end
    tests++; if (obs_wr.size() - wr_base != 3 || n_rd != rd_base) begin
      fails++; $display("FAIL to_xfers got %0d wr %0d rd want 3 wr 0 rd", obs_wr.size() - wr_base, n_rd - rd_base); end
    while (wr_base < obs_wr.size()) begin
      e = (exp_wr.size() != 0) ? exp_wr.pop_front() : 32'hxxxx_xxxx;
      tests++; if (obs_wr[wr_base] !== e) begin
        fails++; $display("FAIL to_wr got %h want %h", obs_wr[wr_base], e); end
      wr_base++;
    end
    no_ack_wr = -1;
    repeat (3) @(negedge wb_clk_i);
    tests++; if (err_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      fails++; $display("FAIL to_err_held got err/busy/done %b%b%b want 100", err_o, busy_o, done_o); end
  endtask

  task automatic test_reset_mid();
    int lat; bit seen; bit hit;
    rsp_blk = FIPS_CT;
    start_seq(FIPS_KEY, FIPS_PT, 1'b1, 1'b0);
    tests++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      fails++; $display("FAIL start_clears_err got err/busy %b%b want 01", err_o, busy_o); end
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk_i);
      if (wbm.wbm_stb_o && !wbm.wbm_we_o && rd_cnt == 1) begin hit = 1'b1; break; end
    end
    tests++; if (!hit) begin
      fails++; $display("FAIL mid_reach_read2 got timeout want read 2 strobe"); end
    #2 wb_rst_ni = 1'b0;
    #1;
    tests++; if ({wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o, wbm.wbm_sel_o} !== 7'h0 ||
                 wbm.wbm_adr_o !== 32'h0 || wbm.wbm_dat_o !== 32'h0) begin
      fails++; $display("FAIL mid_rst_bus got cyc/stb/we/sel %b adr %h want 0", {wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o, wbm.wbm_sel_o}, wbm.wbm_adr_o); end
    tests++; if ({busy_o, done_o, err_o} !== 3'b000 || result_o !== 128'h0) begin
      fails++; $display("FAIL mid_rst_status got %b result %h want 000 / 0", {busy_o, done_o, err_o}, result_o); end
    repeat (3) @(negedge wb_clk_i);
    tests++; if (wbm.wbm_cyc_o !== 1'b0) begin
      fails++; $display("FAIL mid_rst_quiet got cyc=%b want 0", wbm.wbm_cyc_o); end
    wb_rst_ni = 1'b1;
    start_seq(FIPS_KEY, FIPS_PT, 1'b1, 1'b0);
    wait_done(lat, seen);
    tests++; if (!seen || lat != 27 || obs_wr.size() - wr_base != 9 || n_rd - rd_base != 4) begin
      fails++; $display("FAIL mid_rerun got lat %0d wr %0d rd %0d want 27/9/4", lat, obs_wr.size() - wr_base, n_rd - rd_base); end
    tests++; if (result_o !== FIPS_CT) begin
      fails++; $display("FAIL mid_rerun_result got %h want %h", result_o, FIPS_CT); end
  endtask

  task automatic test_busy_restart();
    int lat; bit seen; logic [31:0] e;
    rsp_blk   = FIPS_CT;
    ack_force = 1'b1;
    start_seq(FIPS_KEY, FIPS_PT, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge wb_clk_i);
      if (i == 3) begin key_i = 128'h0; text_i = 128'h0; mode_i = 1'b0; start_i = 1'b1; end
      if (i == 5) start_i = 1'b0;
    end
    wait_done(lat, seen);
    tests++; if (!seen || lat + 6 != 27) begin
      fails++; $display("FAIL busy_latency got %0d (seen=%0b) want 27", lat + 6, seen); end
    tests++; if (result_o !== FIPS_CT || err_o !== 1'b0) begin
      fails++; $display("FAIL busy_result got %h err=%b want %h err=0", result_o, err_o, FIPS_CT); end
    tests++; if (obs_wr.size() - wr_base != 9 || n_rd - rd_base != 4 || gap_bad != gap0) begin
      fails++; $display("FAIL busy_xfers got wr %0d rd %0d gaperr %0d want 9/4/0", obs_wr.size() - wr_base, n_rd - rd_base, gap_bad - gap0); end
    while (wr_base < obs_wr.size()) begin
      e = (exp_wr.size() != 0) ? exp_wr.pop_front() : 32'hxxxx_xxxx;
      tests++; if (obs_wr[wr_base] !== e) begin
        fails++; $display("FAIL busy_wr got %h want %h", obs_wr[wr_base], e); end
      wr_base++;
    end
    repeat (3) @(negedge wb_clk_i);
    tests++; if ({busy_o, wbm.wbm_cyc_o} !== 2'b00) begin
      fails++; $display("FAIL busy_no_restart got busy/cyc %b want 00", {busy_o, wbm.wbm_cyc_o}); end
    ack_force = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_slow_ack();
    test_timeout();
    test_reset_mid();
    test_busy_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_wb_master.md
Name: aes_wb_master

Overview:
Wishbone classic initiator that drives the AES Wishbone slave from a simple local request interface. On start it issues nine single writes to the slave address: four key words, four text words, then the control word. It then issues four single reads to fetch the 128-bit result. It sits between a local controller or test harness and the AES slave, and reports completion or timeout.

Parameters:
BASE_ADR, 32'h3000_0000, address driven on every transfer.
TIMEOUT_CYCLES, 4096, maximum cycles to wait for wbm_ack_i per transfer; must exceed AES core latency.
GAP_CYCLES, 1, cycles wbm_stb_o is held low between transfers; minimum 1.

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous reset, active-low
start_i  in  1  request pulse; sampled only in IDLE
mode_i  in  1  1 = encrypt, 0 = decrypt
order_i  in  1  0 = key words first, 1 = text words first
key_i  in  128  key, latched on accepted start
text_i  in  128  plaintext or ciphertext, latched on accepted start
busy_o  out  1  high from accepted start until DONE or ERR is left
done_o  out  1  one-cycle pulse at end of sequence, success or error
err_o  out  1  high on timeout; held until next accepted start
result_o  out  128  AES output; updated only on success
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte select, always 4'hF while stb is high
wbm_adr_o  out  32  address
wbm_dat_o  out  32  write data
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  slave acknowledge

Behaviour:
- Reset (asynchronous, wb_rst_ni = 0):
  - All outputs go to 0 immediately: cyc, stb, we, sel, adr, dat_o, busy, done, err, result.
  - State goes to IDLE. All counters clear.
  - Reset mid-sequence aborts with no further bus activity.
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE, ERR.
- IDLE:
  - start_i = 1 latches key, text, mode and order, clears err_o, sets busy_o, sets word_idx = 0, and moves to WR_REQ.
  - start_i while busy is ignored.
- Write word ordering:
  - Words 0-3 are the first quad, MSB word first: key[127:96], key[95:64], key[63:32], key[31:0] when order = 0, otherwise the same slicing of text.
  - Words 4-7 are the other quad, same slicing.
  - Word 8 = {3'b000, order, 4'hE, mode ? 8'hEC : 8'hDE, 16'h0000}.
- WR_REQ:
  - cyc = 1, stb = 1, we = 1, sel = F, adr = BASE_ADR, dat_o = word[word_idx].
  - All are stable until ack is sampled high at a posedge.
  - On ack: word_idx increments and state moves to WR_GAP (stb = 0, cyc stays 1).
  - Ack after word 8 may take many cycles while the AES core runs; the timeout still applies.
- WR_GAP:
  - Holds for GAP_CYCLES.
  - Then goes to WR_REQ if word_idx < 9, else to RD_REQ with rd_idx = 0.
- RD_REQ:
  - stb = 1, we = 0, dat_o = 0.
  - On ack, wbm_dat_i is captured into result slice [127-32*rd_idx -: 32], i.e. first read is bits [127:96].
  - Then state moves to RD_GAP.
- RD_GAP:
  - Holds for GAP_CYCLES.
  - Then goes to RD_REQ if rd_idx < 4, else to DONE.
- DONE:
  - cyc = 0. result_o is updated from the capture register. done_o pulses for one cycle, busy_o drops. State returns to IDLE.
- Timeout:
  - A counter runs while stb = 1 and resets at each new request.
  - When it reaches TIMEOUT_CYCLES with no ack, state moves to ERR.
- ERR:
  - cyc = 0, stb = 0, err_o = 1, done_o pulses, busy_o drops. State returns to IDLE.
  - result_o is not modified.
- Ack handling:
  - wbm_ack_i is ignored when stb = 0, including a stale ack held high during a gap.
  - An ack on the same edge as the timeout counter reaching its limit counts as success.
- Latency with zero-wait-state acks and GAP_CYCLES = 1: 13 transfers × 2 cycles + DONE = 27 cycles from start acceptance to done_o.
- Width rules: word_idx is 4 bits, rd_idx is 3 bits, timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package aes_wb_pkg holds:
  - Slave base address.
  - Control-word field constants: ENABLE_NIB = 4'hE, ENC_CODE = 8'hEC, DEC_CODE = 8'hDE, ORDER_KEY_FIRST = 4'h0, ORDER_TEXT_FIRST = 4'h1.
  - Word count constants: 9 writes, 4 reads.
  - Master state encoding.
- The slave uses the same constants.
- No sub-module is needed; the timeout counter and word mux stay inline.

Test Plan:
- FIPS-197 encrypt against the real AES slave: key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, mode = 1, order = 0 -> word 8 = 32'h0EEC0000, result_o = 69c4e0d86a7b0430d8cdb78070b4c55a, done pulse, err = 0.
- Decrypt with order = 1: same key, text 69c4e0d86a7b0430d8cdb78070b4c55a -> word 0 = 32'h69c4e0d8, word 8 = 32'h1EDE0000, result_o = 00112233445566778899aabbccddeeff.
- Zero-wait slave model that acks every strobe next cycle -> exactly 13 strobes, each followed by stb low for 1 cycle, cyc continuous, done_o 27 cycles after start.
- Slave model never acks word 3, TIMEOUT_CYCLES = 16 -> ERR after 16 cycles of stb, cyc/stb drop, err_o = 1, done pulse, result_o unchanged.
- wb_rst_ni asserted during read 2 -> all outputs 0 asynchronously; a new start after release runs a full 13-transfer sequence.
- start_i pulsed while busy, plus ack held high through a gap -> no restart, no extra word advance, sequence completes normally.
